kmeans_frame_loader: RTL and testbench

//  Upstream feeder for the kMeans core. Accepts a bursty byte stream over a valid/ready handshake.

---
 rtl/kmeans_pkg.sv | 18 +
 rtl/kmeans_frame_ram.sv | 27 ++
 rtl/kmeans_frame_loader.sv | 178 +++++++++++++++++
 tb/tb_kmeans_frame_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared definitions for the kMeans loader and core: FSM encoding, point geometry
// and the frame-size defaults both blocks must agree on.
package kmeans_pkg;

    localparam int POINT_W      = 16;
    localparam int COORD_W      = 8;
    localparam int KM_SEED_NUM  = 4;
    localparam int KM_DATA_SIZE = 4096;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEED = 3'd1,
        ST_LOAD = 3'd2,
        ST_WAIT = 3'd3,
        ST_EMIT = 3'd4
    } state_t;

endpackage

// File: rtl/kmeans_frame_ram.sv
// Single-port synchronous frame RAM, one-cycle read latency. Port shape mirrors the
// SHAB90 4096x16 macro so the hard macro can replace this behavioural model.
module kmeans_frame_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/kmeans_frame_loader.sv
// Byte-stream frame loader for the kMeans core: packs bytes into points, buffers one
// frame, replays it as a gapless burst. Optional s_last checking: KMEANS_LOADER_LAST_CHECK_EN.
module kmeans_frame_loader
    import kmeans_pkg::*;
#(
    parameter int SEED_NUM  = KM_SEED_NUM,
    parameter int DATA_SIZE = KM_DATA_SIZE,
    parameter int ADDR_W    = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [COORD_W-1:0] s_data,
    input  logic               s_last,
    input  logic               km_out_valid,
    output logic               in_valid,
    output logic [POINT_W-1:0] in_data,
    output logic               busy,
    output logic               frame_err
);

    localparam int TOTAL  = SEED_NUM + DATA_SIZE;
    localparam int EMIT_W = $clog2(TOTAL);
    localparam int SEED_W = (SEED_NUM > 1) ? $clog2(SEED_NUM) : 1;

    // Upstream handshake: a byte moves on a rising edge only when s_valid && s_ready;
    // s_valid may drop at any time, s_ready depends only on loader state.
    state_t               state, state_nxt;
    logic                 ready_en;
    logic                 parity;
    logic [COORD_W-1:0]   x_q;
    logic [POINT_W-1:0]   seed [SEED_NUM];
    logic [SEED_W-1:0]    seed_cnt;
    logic [ADDR_W-1:0]    point_cnt;
    logic [EMIT_W-1:0]    emit_cnt;
    logic                 km_idle;
    logic [1:0]           km_cnt;

    logic                 accept;
    logic                 point_done;
    logic                 seed_last;
    logic                 load_last;
    logic                 emit_last;
    logic                 final_y;
    logic                 last_err;

    logic                 ram_cs;
    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [ADDR_W-1:0]    rd_addr;
    logic [POINT_W-1:0]   ram_rdata;

    assign s_ready    = ready_en && (state == ST_IDLE || state == ST_SEED || state == ST_LOAD);
    assign busy       = (state == ST_EMIT) || !km_idle;
    assign accept     = s_valid && s_ready;
    assign point_done = accept && parity;
    assign seed_last  = (seed_cnt == SEED_W'(SEED_NUM - 1));
    assign load_last  = (point_cnt == ADDR_W'(DATA_SIZE - 1));
    assign emit_last  = (emit_cnt == EMIT_W'(TOTAL - 1));
    assign final_y    = (state == ST_LOAD) && parity && load_last;

`ifdef KMEANS_LOADER_LAST_CHECK_EN
    assign last_err = accept && (s_last != final_y);
`else
    logic unused_last;
    assign unused_last = s_last ^ final_y;
    assign last_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)                  state_nxt = ST_SEED;
            ST_SEED: if (point_done && seed_last) state_nxt = ST_LOAD;
            ST_LOAD: if (point_done && load_last) state_nxt = ST_WAIT;
            ST_WAIT: if (km_idle)                 state_nxt = ST_EMIT;
            ST_EMIT: if (emit_last)               state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
        if (last_err) begin
            state_nxt = ST_IDLE;
        end
    end

    // Byte packer: even byte parks in x_q, odd byte completes the point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity    <= 1'b0;
            x_q       <= '0;
            seed_cnt  <= '0;
            point_cnt <= '0;
            for (int i = 0; i < SEED_NUM; i++) begin
                seed[i] <= '0;
            end
        end else if (last_err) begin
            parity    <= 1'b0;
            seed_cnt  <= '0;
            point_cnt <= '0;
        end else if (accept) begin
            parity <= !parity;
            if (!parity) begin
                x_q <= s_data;
            end else if (state == ST_SEED) begin
                seed[seed_cnt] <= {x_q, s_data};
                seed_cnt       <= seed_last ? '0 : seed_cnt + SEED_W'(1);
            end else if (state == ST_LOAD) begin
                point_cnt <= load_last ? '0 : point_cnt + ADDR_W'(1);
            end
        end
    end

    // Read address runs one beat ahead of emit_cnt to cover the RAM read latency.
    assign rd_addr  = ADDR_W'(emit_cnt + EMIT_W'(1) - EMIT_W'(SEED_NUM));
    assign ram_we   = point_done && (state == ST_LOAD);
    assign ram_cs   = ram_we || (state == ST_EMIT);
    assign ram_addr = ram_we ? point_cnt : rd_addr;

    kmeans_frame_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (POINT_W)
    ) u_ram (
        .clk   (clk),
        .cs    (ram_cs),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata ({x_q, s_data}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            frame_err <= 1'b0;
            in_valid  <= 1'b0;
            in_data   <= '0;
            emit_cnt  <= '0;
        end else begin
            ready_en  <= 1'b1;
            frame_err <= last_err;
            if (state == ST_EMIT) begin
                in_valid <= 1'b1;
                in_data  <= (emit_cnt < EMIT_W'(SEED_NUM)) ? seed[emit_cnt[SEED_W-1:0]] : ram_rdata;
                emit_cnt <= emit_last ? '0 : emit_cnt + EMIT_W'(1);
            end else begin
                in_valid <= 1'b0;
                in_data  <= '0;
            end
        end
    end

    // Core is considered busy from burst start until it returns SEED_NUM out_valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            km_idle <= 1'b1;
            km_cnt  <= '0;
        end else if (state == ST_WAIT && km_idle) begin
            km_idle <= 1'b0;
            km_cnt  <= '0;
        end else if (!km_idle && km_out_valid) begin
            if (km_cnt == 2'(SEED_NUM - 1)) begin
                km_idle <= 1'b1;
                km_cnt  <= '0;
            end else begin
                km_cnt <= km_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_kmeans_frame_loader.sv
// Directed bench for kmeans_frame_loader: idle/reset vector table plus hand-written
// frame sequences (nominal, bursty, back-to-back, frame-length check, reset mid-emit).
`timescale 1ns/1ps
module tb_kmeans_frame_loader;
    import kmeans_pkg::*;

    localparam int SEEDS = 4;
    localparam int NPTS  = 4096;
    localparam int TOTAL = SEEDS + NPTS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        km_out_valid;
    logic        in_valid;
    logic [15:0] in_data;
    logic        busy;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit stalled = 1'b0;

    logic [15:0] exp_q[$];
    logic [15:0] cur_seeds [SEEDS];

    typedef struct {
        string       name;
        logic        sv;
        logic [7:0]  sd;
        logic        kov;
        logic        e_ready;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [6];

    kmeans_frame_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .km_out_valid (km_out_valid),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pval(input int mode, input int k);
        logic [15:0] v;
        v = 16'(k);
        if (mode == 1) v = v ^ 16'hFFFF;
        return v;
    endfunction

    function automatic void load_exp(input int mode);
        exp_q.delete();
        for (int i = 0; i < SEEDS; i++) exp_q.push_back(cur_seeds[i]);
        for (int k = 0; k < NPTS; k++) exp_q.push_back(pval(mode, k));
    endfunction

    // Entered and left on a negative edge; the byte transfers on the rising edge between.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        int w;
        if (stalled) return;
        for (int i = 0; i < gap; i++) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        w = 0;
        while (!s_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            stalled = 1'b1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            check("byte_accept", 32'(s_ready), 32'd1);
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_seeds(input bit gappy);
        for (int i = 0; i < SEEDS; i++) begin
            send_byte(cur_seeds[i][15:8], 1'b0, gappy ? int'($urandom_range(0, 5)) : 0);
            send_byte(cur_seeds[i][7:0], 1'b0, gappy ? ((i == 0) ? 3 : int'($urandom_range(0, 5))) : 0);
        end
    endtask

    task automatic send_points(input int mode, input int first, input int last_excl,
                               input int last_pt, input int gap_pts);
        logic [15:0] v;
        int g;
        for (int k = first; k < last_excl; k++) begin
            v = pval(mode, k);
            g = (k < gap_pts) ? int'($urandom_range(0, 5)) : 0;
            send_byte(v[15:8], 1'b0, g);
            send_byte(v[7:0], (k == last_pt), g);
        end
    endtask

    task automatic check_burst(input string name, input int budget, output int lat);
        int len;
        int bad;
        logic [15:0] e;
        lat = 0;
        while (!in_valid && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_start"}, 32'(in_valid), 32'd1);
        len = 0;
        bad = 0;
        while (in_valid && len < TOTAL + 16) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
            if (in_data !== e || busy !== 1'b1) bad++;
            len++;
            @(negedge clk);
        end
        check({name, "_len"}, 32'(len), 32'(TOTAL));
        check({name, "_bad_beats"}, 32'(bad), 32'd0);
        check({name, "_data_after"}, 32'(in_data), 32'd0);
        exp_q.delete();
    endtask

    task automatic core_beats(input int n);
        for (int i = 0; i < n; i++) begin
            km_out_valid = 1'b1;
            @(negedge clk);
            km_out_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int iv_seen;

        rst_n        = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        km_out_valid = 1'b0;

        tbl[0] = '{"idle0",   1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0};
        tbl[1] = '{"stray1",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0};
        tbl[2] = '{"stray2",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0};
        tbl[3] = '{"stray3",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0};
        tbl[4] = '{"stray4",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0};
        tbl[5] = '{"novalid", 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_s_ready",   32'(s_ready),   32'd0);
        check("rst_in_valid",  32'(in_valid),  32'd0);
        check("rst_in_data",   32'(in_data),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_state",     32'(dut.state), 32'(ST_IDLE));
        rst_n = 1'b1;

        // Idle after reset, stray core beats must not disturb anything.
        for (int i = 0; i < 6; i++) begin
            s_valid      = tbl[i].sv;
            s_data       = tbl[i].sd;
            km_out_valid = tbl[i].kov;
            @(negedge clk);
            check({tbl[i].name, "_s_ready"},   32'(s_ready),   32'(tbl[i].e_ready));
            check({tbl[i].name, "_in_valid"},  32'(in_valid),  32'(tbl[i].e_valid));
            check({tbl[i].name, "_in_data"},   32'(in_data),   32'(tbl[i].e_data));
            check({tbl[i].name, "_busy"},      32'(busy),      32'(tbl[i].e_busy));
            check({tbl[i].name, "_frame_err"}, 32'(frame_err), 32'(tbl[i].e_err));
        end
        s_valid      = 1'b0;
        km_out_valid = 1'b0;

        // Nominal gapless frame; core idle so WAIT lasts a single cycle.
        cur_seeds[0] = 16'h1010; cur_seeds[1] = 16'h20F0;
        cur_seeds[2] = 16'hF020; cur_seeds[3] = 16'hE0E0;
        load_exp(0);
        send_seeds(1'b0);
        send_points(0, 0, NPTS, NPTS - 1, 0);
        check_burst("t1", 10, lat);
        check("t1_start_lat", 32'(lat), 32'd2);
        check("t1_busy_after", 32'(busy), 32'd1);

        // Bursty second frame loaded while the core is still busy.
        load_exp(0);
        send_seeds(1'b1);
        send_points(0, 0, NPTS, NPTS - 1, 64);
        check("t3_state_wait", 32'(dut.state), 32'(ST_WAIT));
        iv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_valid) iv_seen++;
        end
        for (int b = 0; b < 3; b++) begin
            km_out_valid = 1'b1;
            @(negedge clk);
            if (in_valid) iv_seen++;
            km_out_valid = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (in_valid) iv_seen++;
            end
        end
        check("t3_hold_no_valid", 32'(iv_seen), 32'd0);
        check("t3_state_still_wait", 32'(dut.state), 32'(ST_WAIT));
        km_out_valid = 1'b1;
        @(negedge clk);
        km_out_valid = 1'b0;
        check_burst("t2", 6, lat);
        check("t3_start_after_beat", 32'(lat >= 1 && lat <= 2), 32'd1);

        core_beats(4);
        check("t3_busy_cleared", 32'(busy), 32'd0);

        // Frame-length check: s_last on the y byte of point 100.
        cur_seeds[0] = 16'h0102; cur_seeds[1] = 16'h0304;
        cur_seeds[2] = 16'h0506; cur_seeds[3] = 16'h0708;
        load_exp(1);
        send_seeds(1'b0);
        send_points(1, 0, 101, 100, 0);
`ifdef KMEANS_LOADER_LAST_CHECK_EN
        check("t4_err_pulse", 32'(frame_err), 32'd1);
        @(negedge clk);
        check("t4_err_clear", 32'(frame_err), 32'd0);
        check("t4_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check("t4_ready_idle", 32'(s_ready), 32'd1);
        iv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_valid) iv_seen++;
        end
        check("t4_no_emit", 32'(iv_seen), 32'd0);
        send_seeds(1'b0);
        send_points(1, 0, NPTS, NPTS - 1, 0);
`else
        check("t4_no_err", 32'(frame_err), 32'd0);
        send_points(1, 101, NPTS, NPTS - 1, 0);
`endif
        check_burst("t4", 10, lat);
        check("t4_start_lat", 32'(lat), 32'd2);
        core_beats(4);

        // Reset in the middle of a burst.
        cur_seeds[0] = 16'h1010; cur_seeds[1] = 16'h20F0;
        cur_seeds[2] = 16'hF020; cur_seeds[3] = 16'hE0E0;
        send_seeds(1'b0);
        send_points(0, 0, NPTS, NPTS - 1, 0);
        lat = 0;
        while (!in_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("t5_start", 32'(in_valid), 32'd1);
        repeat (2000) @(negedge clk);
        check("t5_mid_valid", 32'(in_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(in_valid), 32'd0);
        check("t5_async_busy",  32'(busy),     32'd0);
        check("t5_async_ready", 32'(s_ready),  32'd0);
        @(negedge clk);
        check("t5_rst_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_rel_ready", 32'(s_ready),  32'd1);
        check("t5_rel_valid", 32'(in_valid), 32'd0);
        check("t5_rel_busy",  32'(busy),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
